radio_frame_scheduler: RTL and testbench

- Sequences the serial output stream for the radio sample path.
- Accepts 8-bit packed radio samples ({R0_I, R0_Q, R1_I, R1_Q}), buffers them in a small FIFO, and emits framed frames at one bit per SYS_CLK: preamble word, FRAME_WORDS payload words, XOR checksum word.
- Drives the SYNC frame marker and the frame counter consumed by the downstream deserializer and microcontroller.

---
 rtl/radio_frame_scheduler_if.sv | 23 ++
 rtl/radio_frame_scheduler.sv | 147 ++++++++++++++
 tb/tb_radio_frame_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/radio_frame_scheduler_if.sv
// rtl/radio_frame_scheduler_if.sv - sample push, control and framed serial output bundle
interface radio_frame_scheduler_if;
    logic        ENABLE;
    logic [7:0]  SAMPLE_DATA;
    logic        SAMPLE_VALID;
    logic        CLR_OVERRUN;
    logic        DATA_OUT;
    logic        BIT_VALID;
    logic        SYNC;
    logic [15:0] FRAME_CNT;
    logic        OVERRUN;
    logic        BUSY;

    modport master (
        output ENABLE, SAMPLE_DATA, SAMPLE_VALID, CLR_OVERRUN,
        input  DATA_OUT, BIT_VALID, SYNC, FRAME_CNT, OVERRUN, BUSY
    );

    modport slave (
        input  ENABLE, SAMPLE_DATA, SAMPLE_VALID, CLR_OVERRUN,
        output DATA_OUT, BIT_VALID, SYNC, FRAME_CNT, OVERRUN, BUSY
    );
endinterface

// File: rtl/radio_frame_scheduler.sv
// rtl/radio_frame_scheduler.sv - buffers radio samples and serialises preamble/payload/checksum frames
module radio_frame_scheduler #(
    parameter int         FRAME_WORDS = 4,
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                    SYS_CLK,
    input  logic                    RST_N,
    radio_frame_scheduler_if.slave  bus
);
    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH     = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] LAST_WORD = 16'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, CHECKSUM} state_t;

    state_t      state;
    logic [2:0]  bit_idx;
    logic [15:0] word_idx;
    logic [7:0]  word_sr;
    logic [7:0]  csum;
    logic        data_out, bit_valid, sync, busy, overrun;
    logic [15:0] frame_cnt;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [7:0]  head;
    logic        fifo_empty, fifo_full, pop, push, drop;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH);
    // Pops only at a payload word boundary; an empty FIFO there stalls the frame.
    assign pop  = (state == PAYLOAD) && (bit_idx == 3'd0) && !fifo_empty;
    assign push = bus.SAMPLE_VALID && (!fifo_full || pop);
    assign drop = bus.SAMPLE_VALID && fifo_full && !pop;

    assign bus.DATA_OUT  = data_out;
    assign bus.BIT_VALID = bit_valid;
    assign bus.SYNC      = sync;
    assign bus.FRAME_CNT = frame_cnt;
    assign bus.OVERRUN   = overrun;
    assign bus.BUSY      = busy;

    always_ff @(posedge SYS_CLK) begin
        if (push) mem[wr_ptr] <= bus.SAMPLE_DATA;
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop)                 overrun <= 1'b1;
            else if (bus.CLR_OVERRUN) overrun <= 1'b0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            bit_idx   <= '0;
            word_idx  <= '0;
            word_sr   <= '0;
            csum      <= '0;
            data_out  <= 1'b0;
            bit_valid <= 1'b0;
            sync      <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            data_out  <= 1'b0;
            bit_valid <= 1'b0;
            sync      <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= bus.ENABLE;
                    if (bus.ENABLE) begin
                        state     <= PREAMBLE;
                        data_out  <= SYNC_WORD[0];
                        bit_valid <= 1'b1;
                        sync      <= 1'b1;
                        bit_idx   <= 3'd1;
                    end
                end
                PREAMBLE: begin
                    data_out  <= SYNC_WORD[bit_idx];
                    bit_valid <= 1'b1;
                    sync      <= (bit_idx == 3'd0);
                    bit_idx   <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state    <= PAYLOAD;
                        csum     <= '0;
                        word_idx <= '0;
                    end
                end
                PAYLOAD: begin
                    if (bit_idx == 3'd0) begin
                        if (!fifo_empty) begin
                            word_sr   <= head;
                            data_out  <= head[0];
                            bit_valid <= 1'b1;
                            csum      <= csum ^ head;
                            bit_idx   <= 3'd1;
                        end
                    end else begin
                        data_out  <= word_sr[bit_idx];
                        bit_valid <= 1'b1;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (word_idx == LAST_WORD) state <= CHECKSUM;
                            else                       word_idx <= word_idx + 16'd1;
                        end
                    end
                end
                CHECKSUM: begin
                    data_out  <= csum[bit_idx];
                    bit_valid <= 1'b1;
                    bit_idx   <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (bus.ENABLE) begin
                            state <= PREAMBLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_radio_frame_scheduler.sv
// tb/tb_radio_frame_scheduler.sv - directed bench with a queue-based frame model for radio_frame_scheduler
module tb_radio_frame_scheduler;
    localparam int         FW = 4;
    localparam logic [7:0] SW = 8'hA5;
    localparam int         FD = 4;

    logic SYS_CLK = 1'b0;
    logic RST_N   = 1'b1;
    int   tests = 0;
    int   fails = 0;

    radio_frame_scheduler_if bus();

    radio_frame_scheduler #(.FRAME_WORDS(FW), .SYNC_WORD(SW), .FIFO_DEPTH(FD)) dut (
        .SYS_CLK (SYS_CLK),
        .RST_N   (RST_N),
        .bus     (bus)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Model: frame position counted as a plain bit offset, FIFO as a queue.
    bit          m_active = 0;
    int          m_pos = 0;
    logic [7:0]  m_word = 0, m_csum = 0;
    logic [15:0] m_frames = 0;
    bit          m_ovr = 0;
    logic [7:0]  m_q[$];
    logic        e_data = 0, e_valid = 0, e_sync = 0, e_busy = 0;

    always @(posedge SYS_CLK or negedge RST_N) begin
        int pre, off;
        bit popped, dropped;
        if (!RST_N) begin
            m_active = 0; m_pos = 0; m_word = 0; m_csum = 0; m_frames = 0; m_ovr = 0;
            m_q.delete();
            e_data = 0; e_valid = 0; e_sync = 0; e_busy = 0;
        end else begin
            pre = m_q.size(); popped = 0; dropped = 0;
            e_data = 0; e_valid = 0; e_sync = 0;
            if (!m_active) begin
                if (bus.ENABLE) begin
                    m_active = 1; e_valid = 1; e_sync = 1; e_data = SW[0]; m_pos = 1;
                end
            end else if (m_pos < 8) begin
                e_valid = 1; e_sync = (m_pos == 0); e_data = SW[m_pos];
                m_pos++;
                if (m_pos == 8) m_csum = 0;
            end else if (m_pos < 8 + 8*FW) begin
                off = m_pos - 8;
                if (off % 8 == 0) begin
                    if (pre > 0) begin
                        m_word = m_q.pop_front(); popped = 1;
                        m_csum = m_csum ^ m_word;
                        e_valid = 1; e_data = m_word[0]; m_pos++;
                    end
                end else begin
                    e_valid = 1; e_data = m_word[off % 8]; m_pos++;
                end
            end else begin
                off = m_pos - 8 - 8*FW;
                e_valid = 1; e_data = m_csum[off]; m_pos++;
                if (off == 7) begin
                    m_frames = m_frames + 16'd1;
                    if (bus.ENABLE) m_pos = 0;
                    else            m_active = 0;
                end
            end
            if (bus.SAMPLE_VALID) begin
                if (pre == FD && !popped) dropped = 1;
                else m_q.push_back(bus.SAMPLE_DATA);
            end
            if (dropped)              m_ovr = 1;
            else if (bus.CLR_OVERRUN) m_ovr = 0;
            e_busy = m_active;
        end
    end

    always @(negedge SYS_CLK) begin
        tests++;
        if ({bus.DATA_OUT, bus.BIT_VALID, bus.SYNC, bus.OVERRUN, bus.BUSY} !== {e_data, e_valid, e_sync, m_ovr, e_busy}
            || bus.FRAME_CNT !== m_frames) begin
            fails++;
            $display("FAIL cycle_model t=%0t got d/v/s/o/b=%b%b%b%b%b cnt=%0d want %b%b%b%b%b cnt=%0d", $time,
                     bus.DATA_OUT, bus.BIT_VALID, bus.SYNC, bus.OVERRUN, bus.BUSY, bus.FRAME_CNT,
                     e_data, e_valid, e_sync, m_ovr, e_busy, m_frames);
        end
    end

    task automatic tick();
        @(negedge SYS_CLK);
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        #2 RST_N = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.SAMPLE_DATA = d; bus.SAMPLE_VALID = 1'b1;
        tick();
        bus.SAMPLE_VALID = 1'b0;
    endtask

    function automatic logic [47:0] outs();
        return 48'({bus.DATA_OUT, bus.BIT_VALID, bus.SYNC, bus.FRAME_CNT, bus.OVERRUN, bus.BUSY});
    endfunction

    initial begin
        logic [47:0] cap;
        logic [7:0]  last8;
        int nvalid, nsync, nmid, nstall, bits, gaps, cyc;
        bit started, done, prev_valid;

        bus.ENABLE = 0; bus.SAMPLE_DATA = 0; bus.SAMPLE_VALID = 0; bus.CLR_OVERRUN = 0;
        #1 RST_N = 1'b0;
        tick(); tick();
        check("reset_state", outs(), 48'd0);
        RST_N = 1'b1;

        // One frame of 01,02,04,08
        push(8'h01); push(8'h02); push(8'h04); push(8'h08);
        bus.ENABLE = 1; tick(); bus.ENABLE = 0;
        cap = 0; nvalid = 0; nsync = 0;
        for (int i = 0; i < 48; i++) begin
            cap[i] = bus.DATA_OUT; nvalid += int'(bus.BIT_VALID); nsync += int'(bus.SYNC);
            tick();
        end
        check("t1_stream", cap, {8'h0F, 8'h08, 8'h04, 8'h02, 8'h01, 8'hA5});
        check("t1_valid_cycles", 48'(nvalid), 48'd48);
        check("t1_sync_cycles", 48'(nsync), 48'd1);
        check("t1_frame_cnt", 48'(bus.FRAME_CNT), 48'd1);
        check("t1_idle_after", 48'({bus.BUSY, bus.BIT_VALID}), 48'd0);

        // Starved payload: 0x3C every 20 cycles
        bus.ENABLE = 1; started = 0; done = 0; bits = 0; nmid = 0; nstall = 0; last8 = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            bus.SAMPLE_VALID = (c % 20 == 0); bus.SAMPLE_DATA = 8'h3C;
            tick();
            if (bus.BUSY) started = 1;
            if (bus.BIT_VALID) begin
                bus.ENABLE = 0;
                if (bus.SYNC) bits = 0;
                bits++;
                last8 = {bus.DATA_OUT, last8[7:1]};
            end else if (bus.BUSY) begin
                nstall++;
                if (bits % 8 != 0) nmid++;
            end
            if (started && !bus.BUSY) done = 1;
        end
        bus.SAMPLE_VALID = 0;
        check("t2_completed", 48'(done), 48'd1);
        check("t2_mid_word_gaps", 48'(nmid), 48'd0);
        check("t2_stalled", 48'(nstall > 0), 48'd1);
        check("t2_checksum", 48'(last8), 48'h00);
        check("t2_frame_cnt", 48'(bus.FRAME_CNT), 48'd2);

        // Back-to-back frames, prefilled, one sample per 8 cycles
        do_reset();
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        bus.ENABLE = 1; nsync = 0; gaps = 0; prev_valid = 0; cyc = -1;
        for (int c = 0; c < 400 && cyc < 0; c++) begin
            bus.SAMPLE_VALID = (c % 8 == 0); bus.SAMPLE_DATA = 8'(8'h20 + c / 8);
            tick();
            if (bus.SYNC) begin
                nsync++;
                if (nsync > 1 && !prev_valid) gaps++;
            end
            prev_valid = bus.BIT_VALID;
            if (bus.FRAME_CNT == 16'd3) cyc = c;
        end
        bus.ENABLE = 0; bus.SAMPLE_VALID = 0;
        check("t3_third_frame_cycle", 48'(cyc), 48'd143);
        check("t3_sync_count", 48'(nsync), 48'd3);
        check("t3_gaps", 48'(gaps), 48'd0);
        check("t3_overrun", 48'(bus.OVERRUN), 48'd1);
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin tick(); if (!bus.BUSY) done = 1; end
        check("t3_drained", 48'(done), 48'd1);

        // Overrun set/clear
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'h11 + i));
        check("t4_overrun_set", 48'(bus.OVERRUN), 48'd1);
        bus.CLR_OVERRUN = 1; tick(); bus.CLR_OVERRUN = 0;
        check("t4_overrun_clr", 48'(bus.OVERRUN), 48'd0);
        bus.CLR_OVERRUN = 1; push(8'h77); bus.CLR_OVERRUN = 0;
        check("t4_set_wins", 48'(bus.OVERRUN), 48'd1);

        // ENABLE dropped at payload word 1; frame still completes
        bus.ENABLE = 1; tick();
        cap = 0;
        for (int i = 0; i < 48; i++) begin
            if (i == 16) bus.ENABLE = 0;
            cap[i] = bus.DATA_OUT;
            tick();
        end
        check("t5_stream", cap, {8'h04, 8'h14, 8'h13, 8'h12, 8'h11, 8'hA5});
        check("t5_idle", 48'({bus.BUSY, bus.BIT_VALID}), 48'd0);
        nvalid = 0;
        for (int i = 0; i < 5; i++) begin tick(); nvalid += int'(bus.BIT_VALID); end
        check("t5_quiet", 48'(nvalid), 48'd0);
        check("t5_frame_cnt", 48'(bus.FRAME_CNT), 48'd1);

        // Reset mid-payload
        push(8'h55); push(8'hAA);
        bus.ENABLE = 1; tick(); bus.ENABLE = 0;
        repeat (12) tick();
        check("t6_pre_valid", 48'(bus.BIT_VALID), 48'd1);
        #2 RST_N = 1'b0;
        #1 check("t6_async_zero", outs(), 48'd0);
        tick(); tick();
        RST_N = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin tick(); nvalid += int'(bus.BIT_VALID) + int'(bus.BUSY); end
        check("t6_no_output", 48'(nvalid), 48'd0);
        check("t6_frame_cnt", 48'(bus.FRAME_CNT), 48'd0);
        bus.ENABLE = 1; tick(); bus.ENABLE = 0;
        repeat (8) tick();
        check("t6_first_word_stall", 48'({bus.BUSY, bus.BIT_VALID}), 48'b10);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin tick(); if (!bus.BUSY) done = 1; end
        check("t6_finished", 48'({28'd0, done, bus.FRAME_CNT}), {28'd0, 1'b1, 16'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
